rr_arbiter16: RTL and testbench

- Round-robin arbiter that shares one 16-way resource among 16 requesters.
- Grants are driven through the team's 4-to-16 decode scheme: a 4-bit winner index plus enable, expanded to a one-hot grant vector.
- Ownership is held until the owner drops its request, or until a hold-time limit forces rotation.
- Sits between requester blocks and the shared datapath; the datapath consumes `gnt`/`gnt_idx` directly.

---
 rtl/rr_arbiter16_if.sv | 28 ++
 rtl/rr_arbiter16.sv | 123 ++++++++++++
 tb/tb_rr_arbiter16.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the requester blocks and the 16-way round-robin arbiter.
// The requester side drives en/req; the arbiter drives the grant outputs.
interface rr_arbiter16_if;
    logic        en;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters: ownership lasts until release or a hold-time
// limit, with a one-cycle turnaround gap between owners and a one-hot grant decode.
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter16_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       owner_q, owner_d;
    logic             preempt_q, preempt_d;

    logic [3:0]       sel;
    logic             sel_found;
    logic             start_grant;
    logic             owner_req;
    logic             others_req;
    logic             hold_expired;
    logic             grant_on;

    // Rotating priority search: first set request at ptr, ptr+1, ... with 4-bit wrap.
    always_comb begin
        sel       = ptr_q;
        sel_found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!sel_found && bus.req[ptr_q + 4'(i)]) begin
                sel       = ptr_q + 4'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign start_grant  = bus.en && sel_found;
    assign owner_req    = bus.req[owner_q];
    assign others_req   = |(bus.req & ~(16'h0001 << owner_q));
    assign hold_expired = (hold_q == HOLD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; all registers are reset, so no grant can survive rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= 4'd0;
            hold_q    <= '0;
            owner_q   <= 4'd0;
            preempt_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            owner_q   <= owner_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        owner_d   = owner_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (start_grant) begin
                    state_d = GRANT;
                    owner_d = sel;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Release wins over a simultaneous timeout, so preempt stays low then.
                if (!owner_req) begin
                    state_d = GAP;
                    ptr_d   = owner_q + 4'd1;
                end else if (hold_expired && others_req) begin
                    state_d   = GAP;
                    ptr_d     = owner_q + 4'd1;
                    preempt_d = 1'b1;
                end else if (!hold_expired) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend only on registers, so req/en never reach the grant combinationally.
    always_comb begin
        grant_on      = (state_q == GRANT);
        bus.gnt_valid = grant_on;
        bus.gnt_idx   = owner_q;
        bus.preempt   = preempt_q;
        bus.gnt       = grant_on ? (16'h0001 << owner_q) : 16'h0000;
    end

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.gnt));
    a_gnt_matches_valid : assert property (@(posedge clk) disable iff (!rst_n)
        ((bus.gnt != 16'h0000) == bus.gnt_valid));
endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the grant outputs.
module tb_rr_arbiter16;
    typedef struct {
        int         tag;
        logic       v;
        logic [3:0] idx;
        logic       pre;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;
    exp_t sb[$];

    rr_arbiter16_if bus();

    rr_arbiter16 #(
        .MAX_HOLD(8),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive en/req for one cycle; expectation describes outputs after the sampling edge.
    task automatic cyc(input logic e, input logic [15:0] r, input logic v,
                       input logic [3:0] idx, input logic pre);
        exp_t item;
        bus.en  = e;
        bus.req = r;
        @(posedge clk);
        #1;
        item.tag = step;
        item.v   = v;
        item.idx = idx;
        item.pre = pre;
        sb.push_back(item);
        step++;
    endtask

    // Monitor: every cycle with a pending expectation is compared on the falling edge.
    initial begin
        exp_t        e;
        logic [15:0] exp_gnt;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e       = sb.pop_front();
                exp_gnt = e.v ? (16'h0001 << e.idx) : 16'h0000;
                check($sformatf("gnt_valid@%0d", e.tag), 32'(bus.gnt_valid), 32'(e.v));
                check($sformatf("gnt_idx@%0d", e.tag), 32'(bus.gnt_idx), 32'(e.idx));
                check($sformatf("preempt@%0d", e.tag), 32'(bus.preempt), 32'(e.pre));
                check($sformatf("gnt@%0d", e.tag), 32'(bus.gnt), 32'(exp_gnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] mask;
        rst_n   = 1'b1;
        bus.en  = 1'b0;
        bus.req = 16'h0000;
        #2 rst_n = 1'b0;
        #1;
        check("reset_gnt", 32'(bus.gnt), 32'h0);
        check("reset_gnt_idx", 32'(bus.gnt_idx), 32'h0);
        check("reset_gnt_valid", 32'(bus.gnt_valid), 32'h0);
        check("reset_preempt", 32'(bus.preempt), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requester 5: one-cycle latency, release, GAP, IDLE.
        cyc(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 16'h0020, 1'b1, 4'd5, 1'b0);
        cyc(1'b1, 16'h0020, 1'b1, 4'd5, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd5, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd5, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd5, 1'b0);

        // Enable gating (ptr=6): no grant while en=0, then 0 wins the wrapped scan.
        repeat (10) cyc(1'b0, 16'h0011, 1'b0, 4'd5, 1'b0);
        cyc(1'b1, 16'h0011, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 16'h0011, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 16'h0011, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 16'h0010, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 16'h0010, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);

        // Timeout between 3 and 7 (ptr=1): 8 cycles each, preempt gap, back to 3.
        repeat (8) cyc(1'b1, 16'h0088, 1'b1, 4'd3, 1'b0);
        cyc(1'b1, 16'h0088, 1'b0, 4'd3, 1'b1);
        repeat (8) cyc(1'b1, 16'h0088, 1'b1, 4'd7, 1'b0);
        cyc(1'b1, 16'h0088, 1'b0, 4'd7, 1'b1);
        cyc(1'b1, 16'h0088, 1'b1, 4'd3, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd3, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd3, 1'b0);

        // Lone owner keeps the grant past MAX_HOLD; a new competitor preempts at once.
        repeat (12) cyc(1'b1, 16'h0008, 1'b1, 4'd3, 1'b0);
        cyc(1'b1, 16'h0088, 1'b0, 4'd3, 1'b1);
        cyc(1'b1, 16'h0088, 1'b1, 4'd7, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd7, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd7, 1'b0);

        // Release on the timeout cycle counts as release: no preempt (ptr=8).
        repeat (8) cyc(1'b1, 16'h0003, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 16'h0002, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 16'h0002, 1'b1, 4'd1, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd1, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd1, 1'b0);

        // Pointer wrap (ptr=2): 14 releases -> 15 first, then 15 releases -> ptr=0.
        cyc(1'b1, 16'h4000, 1'b1, 4'd14, 1'b0);
        cyc(1'b1, 16'h8001, 1'b0, 4'd14, 1'b0);
        cyc(1'b1, 16'h8001, 1'b1, 4'd15, 1'b0);
        cyc(1'b1, 16'h0001, 1'b0, 4'd15, 1'b0);

        // Full rotation from ptr=0: 0..15,0, each owner drops after 2 granted cycles.
        for (int k = 0; k < 17; k++) begin
            mask = 16'hFFFF & ~(16'h0001 << (k % 16));
            cyc(1'b1, 16'hFFFF, 1'b1, 4'(k % 16), 1'b0);
            cyc(1'b1, 16'hFFFF, 1'b1, 4'(k % 16), 1'b0);
            cyc(1'b1, mask, 1'b0, 4'(k % 16), 1'b0);
        end
        cyc(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);

        // Asynchronous reset while 9 owns the resource.
        cyc(1'b1, 16'h0200, 1'b1, 4'd9, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_gnt", 32'(bus.gnt), 32'h0);
        check("midreset_gnt_valid", 32'(bus.gnt_valid), 32'h0);
        check("midreset_gnt_idx", 32'(bus.gnt_idx), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 16'h0200, 1'b1, 4'd9, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd9, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 4'd9, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
